// File: rtl/riscv_pkg.sv
// Shared RV32I decode types: opcodes, immediate formats,
// decode FSM states and the ID/EX pipeline bundle.
package riscv_pkg;

  localparam int XW = 32;
  localparam int RW = 5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_type_t;

  typedef enum logic {
    ST_RUN,
    ST_WB_WAIT
  } id_state_t;

  typedef struct packed {
    logic [XW-1:0] pc;
    logic [XW-1:0] a;
    logic [XW-1:0] b;
    logic [XW-1:0] imm;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic [RW-1:0] rd;
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic          funct7b5;
    logic          is_load;
  } id_ex_t;

endpackage

// File: rtl/id_operand_stage_imm_gen.sv
// Immediate generator: classifies instr by opcode and builds
// the sign-extended immediate. Ports: instr in; imm_type, imm out.
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  output imm_type_t   imm_type,
  output logic [31:0] imm
);

  logic [6:0] op;
  assign op = instr[6:0];

  always_comb begin
    imm_type = IMM_NONE;
    unique case (1'b1)
      (op == OP_LOAD) || (op == OP_OPIMM) || (op == OP_JALR):
        imm_type = IMM_I;
      (op == OP_STORE):
        imm_type = IMM_S;
      (op == OP_BRANCH):
        imm_type = IMM_B;
      (op == OP_LUI) || (op == OP_AUIPC):
        imm_type = IMM_U;
      (op == OP_JAL):
        imm_type = IMM_J;
      default:
        imm_type = IMM_NONE;
    endcase
  end

  always_comb begin
    imm = '0;
    unique case (imm_type)
      IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm = {{20{instr[31]}}, instr[31:25],
                    instr[11:7]};
      IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm = {instr[31:12], 12'b0};
      IMM_J: imm = {{11{instr[31]}}, instr[31],
                    instr[19:12], instr[20],
                    instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/id_operand_stage.sv
// Decode/operand-fetch stage: regfile reads, immediates, load-use
// and writeback hazards, ID/EX register with valid/ready handshake.
// Ports: id_* from IF/ID, ra*/rd* regfile, wb_* writeback, flush,
// ex_* to execute. Macro ID_WB_BYPASS_EN forwards same-cycle wb data
// instead of stalling one cycle in WB_WAIT.
module id_operand_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [31:0]     id_instr,
  input  logic [XLEN-1:0] id_pc,
  output logic [AW-1:0]   ra1,
  output logic [AW-1:0]   ra2,
  input  logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] rd2,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_wa,
  input  logic [XLEN-1:0] wb_wd,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [XLEN-1:0] ex_imm,
  output logic [AW-1:0]   ex_rs1,
  output logic [AW-1:0]   ex_rs2,
  output logic [AW-1:0]   ex_rd,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic            ex_is_load
);

  logic [6:0]    op;
  logic [AW-1:0] rs1, rs2, rd;
  imm_type_t     imm_type;
  logic [31:0]   imm;
  logic          uses_rs1, uses_rs2;
  logic          slot_free, load_hz;
  logic          wb_hz_raw, wb_hz;
  logic          accept;
  logic [XLEN-1:0] opa, opb;
  id_state_t     state, state_d;
  id_ex_t        ex_q, ex_d;
  logic          valid_q;

  assign op  = id_instr[6:0];
  assign rs1 = id_instr[19:15];
  assign rs2 = id_instr[24:20];
  assign rd  = id_instr[11:7];
  assign ra1 = rs1;
  assign ra2 = rs2;

  imm_gen u_imm (
    .instr    (id_instr),
    .imm_type (imm_type),
    .imm      (imm)
  );

  assign uses_rs1 = !((op == OP_LUI) || (op == OP_AUIPC) ||
                      (op == OP_JAL));
  assign uses_rs2 = (op == OP_OP) || (imm_type == IMM_S) ||
                    (imm_type == IMM_B);

  assign slot_free = !valid_q || ex_ready;

  assign load_hz = valid_q && ex_q.is_load &&
                   (ex_q.rd != '0) &&
                   ((uses_rs1 && rs1 == ex_q.rd) ||
                    (uses_rs2 && rs2 == ex_q.rd));

`ifdef ID_WB_BYPASS_EN
  logic byp1, byp2;
  assign byp1 = wb_we && (wb_wa != '0) && (wb_wa == rs1);
  assign byp2 = wb_we && (wb_wa != '0) && (wb_wa == rs2);
  assign opa = (rs1 == '0) ? '0 : (byp1 ? wb_wd : rd1);
  assign opb = (rs2 == '0) ? '0 : (byp2 ? wb_wd : rd2);
  assign wb_hz_raw = 1'b0;
`else
  logic unused_wd;
  assign unused_wd = ^wb_wd;
  assign opa = (rs1 == '0) ? '0 : rd1;
  assign opb = (rs2 == '0) ? '0 : rd2;
  assign wb_hz_raw = wb_we && (wb_wa != '0) &&
                     ((uses_rs1 && wb_wa == rs1) ||
                      (uses_rs2 && wb_wa == rs2));
`endif

  // One stall cycle lets the regfile absorb the write;
  // in WB_WAIT the hazard is ignored and the read is fresh.
  always_comb begin
    state_d = ST_RUN;
    wb_hz   = 1'b0;
    unique case (state)
      ST_RUN: begin
        wb_hz = wb_hz_raw;
        if (wb_hz_raw && !flush)
          state_d = ST_WB_WAIT;
      end
      ST_WB_WAIT: state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase
  end

  assign id_ready = rst_n && !flush && slot_free &&
                    !load_hz && !wb_hz;
  assign accept = id_valid && id_ready;

  always_comb begin
    ex_d          = '0;
    ex_d.pc       = id_pc;
    ex_d.a        = opa;
    ex_d.b        = opb;
    ex_d.imm      = imm;
    ex_d.rs1      = rs1;
    ex_d.rs2      = rs2;
    ex_d.rd       = rd;
    ex_d.opcode   = op;
    ex_d.funct3   = id_instr[14:12];
    ex_d.funct7b5 = id_instr[30];
    ex_d.is_load  = (op == OP_LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ex_q    <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      ex_q    <= ex_d;
    end else if (slot_free) begin
      valid_q <= 1'b0;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_pc       = ex_q.pc;
  assign ex_a        = ex_q.a;
  assign ex_b        = ex_q.b;
  assign ex_imm      = ex_q.imm;
  assign ex_rs1      = ex_q.rs1;
  assign ex_rs2      = ex_q.rs2;
  assign ex_rd       = ex_q.rd;
  assign ex_opcode   = ex_q.opcode;
  assign ex_funct3   = ex_q.funct3;
  assign ex_funct7b5 = ex_q.funct7b5;
  assign ex_is_load  = ex_q.is_load;

endmodule

// File: tb/tb_id_operand_stage.sv
// Randomized bench for id_operand_stage against a cycle model
// of the decode stage, plus directed scenarios with literal checks.
module tb_id_operand_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        f7b5;
    logic        is_load;
  } exp_t;

  logic        clk = 0;
  logic        rst_n;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc;
  logic [4:0]  ra1, ra2;
  logic [31:0] rd1, rd2;
  logic        wb_we;
  logic [4:0]  wb_wa;
  logic [31:0] wb_wd;
  logic        flush, ex_ready, ex_valid;
  logic [31:0] ex_pc, ex_a, ex_b, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5, ex_is_load;

  id_operand_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .flush(flush), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
    .ex_funct7b5(ex_funct7b5), .ex_is_load(ex_is_load)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] regs [32];
  exp_t        m;
  logic        m_v;
  logic        m_wait;

  localparam logic [31:0] ADDI = 32'hFFF08293;
  localparam logic [31:0] LW   = 32'h00012183;
  localparam logic [31:0] ADD  = 32'h00118233;
  localparam logic [31:0] LUI  = 32'h123451B7;
  localparam logic [31:0] ADD8 = 32'h00038433;
  localparam logic [31:0] ADDZ = 32'h00000433;
  localparam logic [31:0] BEQ  = 32'hFE000EE3;

  task automatic chk(input string nm, input logic [154:0] act,
                     input logic [154:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t dut_b();
    return {ex_pc, ex_a, ex_b, ex_imm, ex_rs1, ex_rs2, ex_rd,
            ex_opcode, ex_funct3, ex_funct7b5, ex_is_load};
  endfunction

  // Immediate from format rules using arithmetic shifts.
  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    logic signed [31:0] s;
    logic [31:0] hi;
    s = w;
    hi = 32'(s >>> 31);
    case (w[6:0])
      7'b0000011, 7'b0010011, 7'b1100111:
        return 32'(s >>> 20);
      7'b0100011:
        return (32'(s >>> 25) << 5) | 32'(w[11:7]);
      7'b1100011:
        return (hi << 12) | (32'(w[7]) << 11) |
               (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
      7'b0110111, 7'b0010111:
        return w & 32'hFFFFF000;
      7'b1101111:
        return (hi << 20) | (32'(w[19:12]) << 12) |
               (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] oper(input logic [4:0] i,
      input logic we, input logic [4:0] wa,
      input logic [31:0] wd);
    if (i == 0) return 32'h0;
`ifdef ID_WB_BYPASS_EN
    if (we && wa == i) return wd;
`endif
    return regs[i];
  endfunction

  task automatic cycle(input logic v, input logic [31:0] ins,
      input logic [31:0] pc, input logic fl, input logic er,
      input logic we, input logic [4:0] wa,
      input logic [31:0] wd, output logic acc);
    logic [6:0] op;
    logic [4:0] s1, s2;
    logic u1, u2, sf, lh, wh, rdy;
    exp_t nx;
    id_valid = v; id_instr = ins; id_pc = pc; flush = fl;
    ex_ready = er; wb_we = we; wb_wa = wa; wb_wd = wd;
    s1 = ins[19:15];
    s2 = ins[24:20];
    rd1 = regs[s1];
    rd2 = regs[s2];
    #1;
    op = ins[6:0];
    u1 = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
    u2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
    sf = !m_v || er;
    lh = m_v && m.opcode == 7'b0000011 && m.rd != 0 &&
         ((u1 && s1 == m.rd) || (u2 && s2 == m.rd));
`ifdef ID_WB_BYPASS_EN
    wh = 1'b0;
`else
    wh = !m_wait && we && wa != 0 &&
         ((u1 && wa == s1) || (u2 && wa == s2));
`endif
    rdy = !fl && sf && !lh && !wh;
    chk("id_ready", id_ready, rdy);
    chk("ra", {ra1, ra2}, {s1, s2});
    acc = v && rdy;
    if (acc) begin
      nx.pc = pc;
      nx.a = oper(s1, we, wa, wd);
      nx.b = oper(s2, we, wa, wd);
      nx.imm = ref_imm(ins);
      nx.rs1 = s1;
      nx.rs2 = s2;
      nx.rd = ins[11:7];
      nx.opcode = op;
      nx.funct3 = ins[14:12];
      nx.f7b5 = ins[30];
      nx.is_load = (op == 7'b0000011);
      m = nx;
      m_v = 1'b1;
    end else if (fl || sf) begin
      m_v = 1'b0;
    end
    m_wait = wh && !fl;
    if (we && wa != 0) regs[wa] = wd;
    @(posedge clk);
    @(negedge clk);
    chk("ex_valid", ex_valid, m_v);
    if (m_v) chk("ex_bundle", dut_b(), m);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    id_valid = 1'b1;
    #1;
    chk("rst_valid", ex_valid, 1'b0);
    chk("rst_bundle", dut_b(), 155'd0);
    chk("rst_ready", id_ready, 1'b0);
    m = '0;
    m_v = 1'b0;
    m_wait = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready_hold", id_ready, 1'b0);
    chk("rst_valid_hold", ex_valid, 1'b0);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 8))
      0: w[6:0] = 7'b0000011;
      1: w[6:0] = 7'b0100011;
      2: w[6:0] = 7'b1100011;
      3: w[6:0] = 7'b1101111;
      4: w[6:0] = 7'b1100111;
      5: w[6:0] = 7'b0110111;
      6: w[6:0] = 7'b0010111;
      7: w[6:0] = 7'b0110011;
      default: w[6:0] = 7'b0010011;
    endcase
    w[11:7] = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    return w;
  endfunction

  initial begin
    logic acc;
    logic [31:0] ci, cp;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 32'h0;
    regs[1] = 32'h10;
    rst_n = 0; id_valid = 1; id_instr = ADDI; id_pc = 0;
    rd1 = 0; rd2 = 0; wb_we = 0; wb_wa = 0; wb_wd = 0;
    flush = 0; ex_ready = 1;
    m = '0; m_v = 0; m_wait = 0;
    repeat (2) @(negedge clk);
    do_reset();

    cycle(1, ADDI, 32'h100, 0, 1, 0, 0, 0, acc);
    chk("addi_valid", ex_valid, 1'b1);
    chk("addi_a", ex_a, 32'h10);
    chk("addi_imm", ex_imm, 32'hFFFFFFFF);
    chk("addi_rd", ex_rd, 5'd5);

    cycle(1, LW, 32'h104, 0, 1, 0, 0, 0, acc);
    cycle(1, ADD, 32'h108, 0, 1, 0, 0, 0, acc);
    chk("lu_bubble_acc", acc, 1'b0);
    chk("lu_bubble", ex_valid, 1'b0);
    cycle(1, ADD, 32'h108, 0, 1, 0, 0, 0, acc);
    chk("lu_add_valid", ex_valid, 1'b1);
    chk("lu_add_rs1", ex_rs1, 5'd3);
    cycle(1, LW, 32'h10C, 0, 1, 0, 0, 0, acc);
    cycle(1, LUI, 32'h110, 0, 1, 0, 0, 0, acc);
    chk("lui_no_bubble", ex_valid, 1'b1);
    chk("lui_pc", ex_pc, 32'h110);

    cycle(1, ADD8, 32'h114, 0, 1, 1, 5'd7, 32'hDEADBEEF, acc);
`ifndef ID_WB_BYPASS_EN
    chk("wb_stall", ex_valid, 1'b0);
    cycle(1, ADD8, 32'h114, 0, 1, 0, 0, 0, acc);
`endif
    chk("wb_a", ex_a, 32'hDEADBEEF);
    chk("wb_pc", ex_pc, 32'h114);
    cycle(1, ADDZ, 32'h118, 0, 1, 1, 5'd0, 32'h55, acc);
    chk("wb_x0_a", ex_a, 32'h0);

    cycle(1, ADDI, 32'h200, 0, 1, 0, 0, 0, acc);
    for (int k = 0; k < 3; k++) begin
      cycle(1, ADD, 32'h204, 0, 0, 0, 0, 0, acc);
      chk("stall_pc", ex_pc, 32'h200);
    end
    cycle(1, ADD, 32'h204, 0, 1, 0, 0, 0, acc);
    chk("stall_resume", ex_pc, 32'h204);
    cycle(0, ADD, 32'h208, 0, 1, 0, 0, 0, acc);
    chk("stall_nodup", ex_valid, 1'b0);

    cycle(1, ADDI, 32'h300, 0, 1, 0, 0, 0, acc);
    cycle(1, BEQ, 32'h304, 1, 0, 0, 0, 0, acc);
    chk("flush_valid", ex_valid, 1'b0);
    cycle(1, BEQ, 32'h400, 0, 1, 0, 0, 0, acc);
    chk("beq_imm", ex_imm, 32'hFFFFFFFC);

    cycle(1, ADDI, 32'h500, 0, 1, 0, 0, 0, acc);
    cycle(1, ADD, 32'h504, 0, 0, 0, 0, 0, acc);
    do_reset();
    cycle(1, ADD8, 32'h508, 0, 1, 1, 5'd7, 32'h1234, acc);
    do_reset();
    cycle(1, ADD8, 32'h508, 0, 1, 0, 0, 0, acc);
    chk("post_rst_acc", ex_pc, 32'h508);

    ci = rnd_instr();
    cp = 32'h1000;
    for (int n = 0; n < 3000; n++) begin
      logic v, fl, er, we;
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end
      v  = ($urandom_range(0, 9) < 8);
      fl = ($urandom_range(0, 19) == 0);
      er = ($urandom_range(0, 9) < 7);
      we = ($urandom_range(0, 9) < 4);
      cycle(v, ci, cp, fl, er, we,
            5'($urandom_range(0, 7)), $urandom, acc);
      if (acc || fl) begin
        ci = rnd_instr();
        cp = cp + 32'd4;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
